bcd_digit_packer: RTL and testbench

- Downstream consumer of the BCD digit checker. Accepts a serial stream of 4-bit digits plus the checker's invalid flag, and packs DIGITS consecutive valid digits (most-significant first) into one packed-BCD word.
- Presents the packed word on a valid/ready output handshake.
- On an invalid digit it aborts the partial word and reports an error. Sits between the checker and any BCD arithmetic or display stage.

---
 rtl/bcd_digit_packer_if.sv | 31 +++
 rtl/bcd_digit_packer.sv | 104 ++++++++++
 tb/tb_bcd_digit_packer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_digit_packer_if.sv
// Digit-in / word-out bundle for the BCD digit packer.
// master: the packer (drives digit_ready, word bus, error status).
// slave: the environment (drives digits, clear, word_ready).
interface bcd_digit_packer_if #(
    parameter int DIGITS = 4,
    parameter int ERRW   = 8
);
    localparam int CW = $clog2(DIGITS + 1);

    logic [3:0]          digit_in;
    logic                digit_valid;
    logic                bcd_flag;
    logic                digit_ready;
    logic                clear;
    logic [4*DIGITS-1:0] word_out;
    logic                word_valid;
    logic                word_ready;
    logic                err;
    logic [ERRW-1:0]     err_count;
    logic [CW-1:0]       digit_cnt;

    modport master (
        input  digit_in, digit_valid, bcd_flag, clear, word_ready,
        output digit_ready, word_out, word_valid, err, err_count, digit_cnt
    );

    modport slave (
        output digit_in, digit_valid, bcd_flag, clear, word_ready,
        input  digit_ready, word_out, word_valid, err, err_count, digit_cnt
    );
endinterface

// File: rtl/bcd_digit_packer.sv
// Packs DIGITS checked BCD digits (MS first) into one packed-BCD word.
// Latency: word_valid the cycle after the last digit handshake; err the cycle after an invalid digit.
// Backpressure: digit_ready low while a word is held (HOLD) or during the one-cycle ERR state.
module bcd_digit_packer #(
    parameter int DIGITS = 4,
    parameter int ERRW   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bcd_digit_packer_if.master     bus
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int AW = 4 * DIGITS;

    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DIGITS - 1);
    localparam logic [ERRW-1:0] ERR_ONE  = ERRW'(1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q,   acc_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [ERRW-1:0] errcnt_q, errcnt_d;

    // Outputs come straight from state/registers; a flagged digit never
    // enters the accumulator, so word_out only ever holds nibbles 0-9.
    assign bus.digit_ready = (state_q == FILL);
    assign bus.word_valid  = (state_q == HOLD);
    assign bus.err         = (state_q == ERR);
    assign bus.word_out    = acc_q;
    assign bus.digit_cnt   = cnt_q;
    assign bus.err_count   = errcnt_q;

    // State and datapath registers; reset discards any partial or held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            acc_q    <= '0;
            cnt_q    <= '0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            errcnt_q <= errcnt_d;
        end
    end

    // Next-state logic: clear outranks everything; the digit offered with
    // clear is silently dropped and never counted as an error.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        errcnt_d = errcnt_q;
        if (bus.clear) begin
            state_d = FILL;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (bus.digit_valid) begin
                        if (bus.bcd_flag) begin
                            state_d = ERR;
                            acc_d   = '0;
                            cnt_d   = '0;
                            if (errcnt_q != '1) begin
                                errcnt_d = errcnt_q + ERR_ONE;
                            end
                        end else begin
                            acc_d = {acc_q[AW-5:0], bus.digit_in};
                            cnt_d = cnt_q + CNT_ONE;
                            if (cnt_q == CNT_LAST) begin
                                state_d = HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    // Handoff cycle: no digit is taken, word clears for the next fill.
                    if (bus.word_ready) begin
                        state_d = FILL;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                ERR: begin
                    state_d = FILL;
                end
                default: begin
                    state_d = FILL;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_digit_packer.sv
// Directed bench for bcd_digit_packer with an expected-word scoreboard.
module tb_bcd_digit_packer;
    logic clk;
    logic rst_n;

    bcd_digit_packer_if #(.DIGITS(4), .ERRW(8)) bus  ();
    bcd_digit_packer_if #(.DIGITS(4), .ERRW(2)) bus2 ();

    bcd_digit_packer #(.DIGITS(4), .ERRW(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    bcd_digit_packer #(.DIGITS(4), .ERRW(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [15:0] sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $error("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one digit and hold it until the packer takes it (bounded).
    task automatic send(input logic [3:0] d, input logic f);
        int n;
        bus.digit_in    = d;
        bus.bcd_flag    = f;
        bus.digit_valid = 1'b1;
        n = 0;
        while (!bus.digit_ready && n < 50) begin
            step();
            n++;
        end
        if (!bus.digit_ready) check("tmo_digit_ready", {31'd0, bus.digit_ready}, 32'd1);
        step();
    endtask

    task automatic idle();
        bus.digit_valid = 1'b0;
        bus.bcd_flag    = 1'b0;
        bus.digit_in    = 4'h0;
    endtask

    task automatic push_word(input logic [15:0] w);
        sb_q.push_back(w);
    endtask

    // Compare the presented word against the scoreboard head.
    task automatic pop_check(input string tag);
        logic [15:0] e;
        int n;
        n = 0;
        while (!bus.word_valid && n < 50) begin
            step();
            n++;
        end
        check({tag, "_valid"}, {31'd0, bus.word_valid}, 32'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_word"}, {16'd0, bus.word_out}, {16'd0, e});
        end
    endtask

    initial begin
        logic [1:0] exp2;
        rst_n = 1'b0;
        idle();
        bus.clear       = 1'b0;
        bus.word_ready  = 1'b1;
        bus2.digit_in    = 4'h0;
        bus2.digit_valid = 1'b0;
        bus2.bcd_flag    = 1'b0;
        bus2.clear       = 1'b0;
        bus2.word_ready  = 1'b1;
        #12;
        check("rst_word_valid", {31'd0, bus.word_valid}, 32'd0);
        check("rst_err",        {31'd0, bus.err},        32'd0);
        check("rst_word_out",   {16'd0, bus.word_out},   32'd0);
        check("rst_digit_cnt",  {29'd0, bus.digit_cnt},  32'd0);
        check("rst_err_count",  {24'd0, bus.err_count},  32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rst_digit_ready", {31'd0, bus.digit_ready}, 32'd1);

        // 1: basic word with downstream always ready
        push_word(16'h1234);
        send(4'd1, 1'b0); send(4'd2, 1'b0); send(4'd3, 1'b0); send(4'd4, 1'b0);
        idle();
        check("t1_valid_now", {31'd0, bus.word_valid}, 32'd1);
        pop_check("t1");
        check("t1_ready_hold", {31'd0, bus.digit_ready}, 32'd0);
        step();
        check("t1_valid_drop", {31'd0, bus.word_valid}, 32'd0);
        check("t1_cnt_zero",   {29'd0, bus.digit_cnt},  32'd0);

        // 2: invalid digit aborts the partial word
        send(4'd9, 1'b0); send(4'd8, 1'b0);
        idle();
        check("t2_cnt2", {29'd0, bus.digit_cnt}, 32'd2);
        send(4'hB, 1'b1);
        idle();
        check("t2_err_pulse",   {31'd0, bus.err},         32'd1);
        check("t2_err_count",   {24'd0, bus.err_count},   32'd1);
        check("t2_ready_err",   {31'd0, bus.digit_ready}, 32'd0);
        check("t2_cnt_cleared", {29'd0, bus.digit_cnt},   32'd0);
        step();
        check("t2_err_drop", {31'd0, bus.err},         32'd0);
        check("t2_ready_back", {31'd0, bus.digit_ready}, 32'd1);
        push_word(16'h7654);
        send(4'd7, 1'b0); send(4'd6, 1'b0); send(4'd5, 1'b0); send(4'd4, 1'b0);
        idle();
        pop_check("t2");
        step();

        // 3: backpressure with a digit offered during HOLD
        bus.word_ready = 1'b0;
        push_word(16'h5009);
        send(4'd5, 1'b0); send(4'd0, 1'b0); send(4'd0, 1'b0); send(4'd9, 1'b0);
        bus.digit_in    = 4'd7;
        bus.digit_valid = 1'b1;
        pop_check("t3");
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold_valid", {31'd0, bus.word_valid},  32'd1);
            check("t3_hold_word",  {16'd0, bus.word_out},    32'h5009);
            check("t3_hold_ready", {31'd0, bus.digit_ready}, 32'd0);
        end
        bus.word_ready = 1'b1;
        check("t3_handoff_ready", {31'd0, bus.digit_ready}, 32'd0);
        step();
        idle();
        check("t3_after_valid", {31'd0, bus.word_valid}, 32'd0);
        check("t3_after_cnt",   {29'd0, bus.digit_cnt},  32'd0);

        // 4: clear drops the concurrent digit without flagging it
        send(4'd3, 1'b0); send(4'd3, 1'b0);
        idle();
        check("t4_cnt2", {29'd0, bus.digit_cnt}, 32'd2);
        bus.digit_in    = 4'd7;
        bus.digit_valid = 1'b1;
        bus.clear       = 1'b1;
        step();
        bus.clear = 1'b0;
        idle();
        check("t4_cnt_clr",   {29'd0, bus.digit_cnt}, 32'd0);
        check("t4_word_clr",  {16'd0, bus.word_out},  32'd0);
        check("t4_no_err",    {31'd0, bus.err},       32'd0);
        check("t4_err_count", {24'd0, bus.err_count}, 32'd1);
        push_word(16'h0001);
        send(4'd0, 1'b0); send(4'd0, 1'b0); send(4'd0, 1'b0); send(4'd1, 1'b0);
        idle();
        pop_check("t4");
        step();

        // 5: asynchronous reset while holding a word
        bus.word_ready = 1'b0;
        push_word(16'h4321);
        send(4'd4, 1'b0); send(4'd3, 1'b0); send(4'd2, 1'b0); send(4'd1, 1'b0);
        idle();
        pop_check("t5");
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_valid",     {31'd0, bus.word_valid}, 32'd0);
        check("t5_word",      {16'd0, bus.word_out},   32'd0);
        check("t5_err_count", {24'd0, bus.err_count},  32'd0);
        check("t5_cnt",       {29'd0, bus.digit_cnt},  32'd0);
        step();
        rst_n = 1'b1;
        bus.word_ready = 1'b1;
        step();

        // 6: saturating 2-bit error counter
        exp2 = 2'd0;
        for (int i = 0; i < 5; i++) begin
            int n;
            bus2.digit_in    = 4'hC;
            bus2.bcd_flag    = 1'b1;
            bus2.digit_valid = 1'b1;
            n = 0;
            while (!bus2.digit_ready && n < 50) begin
                step();
                n++;
            end
            if (!bus2.digit_ready) check("t6_tmo_ready", {31'd0, bus2.digit_ready}, 32'd1);
            step();
            bus2.digit_valid = 1'b0;
            bus2.bcd_flag    = 1'b0;
            if (exp2 != 2'd3) exp2 = exp2 + 2'd1;
            check("t6_err_pulse", {31'd0, bus2.err},       32'd1);
            check("t6_err_count", {30'd0, bus2.err_count}, {30'd0, exp2});
            step();
            check("t6_err_low", {31'd0, bus2.err}, 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
